ball_axis_counter: RTL and testbench

//  Parametrised ball-position counter for one screen axis; successor to the fixed 9-bit vertical counter.

---
 rtl/ball_axis_counter.sv | 194 +++++++++++++++++++
 tb/tb_ball_axis_counter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ball_axis_counter.sv
// ball_axis_counter
// -----------------
// Ball-position counter for one screen axis. POS advances on every enabled
// line (or pixel) strobe and, at terminal count, reloads with
// BASE_LOAD +/- MAG. Because the reload value moves with the latched speed,
// the ball window (the top BALL_H counts of the range) shifts a little each
// frame. The hitting player's paddle segment sets speed and direction.
// An optional wall bounce reverses direction.
//
// Everything runs on CLK_DRV. LINE_STB, FRAME_STB and HIT are one-cycle
// enables, not clocks.
//
// Configuration macro:
//   BALL_AXIS_WALL_BOUNCE_EN  defined   : FRAME_STB while the ball window is
//                                         active toggles DIR. Use this for the
//                                         vertical axis (top/bottom walls).
//                             undefined : DIR changes only on HIT, ATTRACT or
//                                         reset. Use this for the horizontal
//                                         axis.
//
// Ports:
//   CLK_DRV    in   1                   system clock, rising edge
//   RST_N      in   1                   asynchronous active-low reset
//   LINE_STB   in   1                   count strobe
//   CNT_EN     in   1                   count enable (active-video gate)
//   FRAME_STB  in   1                   pulse at start of vertical blank
//   HIT        in   1                   paddle-hit pulse
//   SIDE       in   SIDE_W              hitting player index, sampled with HIT
//   SEG        in   NPLAYERS*(MAG_W+1)  packed paddle segment codes
//   ATTRACT    in   1                   attract mode, forces speed to zero
//   POS        out  CNT_W               current count
//   BALL_VID   out  1                   ball window active
//   BALL_VID_N out  1                   complement of BALL_VID
//   WRAP       out  1                   high in the cycle POS shows the reload
//   DIR        out  1                   0: reload adds MAG, 1: reload subtracts
//   MAG        out  MAG_W               latched speed magnitude

module ball_axis_counter #(
    parameter int CNT_W     = 9,
    parameter int MAG_W     = 2,
    parameter int NPLAYERS  = 2,
    parameter int BALL_H    = 4,
    parameter int BASE_LOAD = 4,
    localparam int SIDE_W   = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1,
    localparam int SEG_W    = MAG_W + 1
) (
    input  logic                      CLK_DRV,
    input  logic                      RST_N,
    input  logic                      LINE_STB,
    input  logic                      CNT_EN,
    input  logic                      FRAME_STB,
    input  logic                      HIT,
    input  logic [SIDE_W-1:0]         SIDE,
    input  logic [NPLAYERS*SEG_W-1:0] SEG,
    input  logic                      ATTRACT,
    output logic [CNT_W-1:0]          POS,
    output logic                      BALL_VID,
    output logic                      BALL_VID_N,
    output logic                      WRAP,
    output logic                      DIR,
    output logic [MAG_W-1:0]          MAG
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] MAX_POS   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] BASE_POS  = CNT_W'(BASE_LOAD);
    // The ball window is the last BALL_H counts before terminal count.
    localparam logic [CNT_W-1:0] VID_START = CNT_W'((1 << CNT_W) - BALL_H);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] pos_q,  pos_d;
    logic             wrap_q, wrap_d;
    logic [MAG_W-1:0] mag_q,  mag_d;
    logic             dir_q,  dir_d;

    // ------------------------------------------------------------------
    // Decodes
    // ------------------------------------------------------------------
    logic             count_stb;
    logic             at_max;
    logic [CNT_W-1:0] load_val;
    logic             ball_vid;

    assign count_stb = LINE_STB & CNT_EN;
    assign at_max    = (pos_q == MAX_POS);
    assign ball_vid  = (pos_q >= VID_START);

    // The reload uses the registered MAG/DIR. A HIT in the wrap cycle
    // therefore takes effect only at the following reload. The arithmetic
    // wraps modulo 2^CNT_W.
    always_comb begin
        if (dir_q) begin
            load_val = BASE_POS - CNT_W'(mag_q);
        end else begin
            load_val = BASE_POS + CNT_W'(mag_q);
        end
    end

    // ------------------------------------------------------------------
    // Position counter next state
    // ------------------------------------------------------------------
    always_comb begin
        pos_d  = pos_q;
        wrap_d = 1'b0;
        if (count_stb) begin
            if (at_max) begin
                pos_d  = load_val;
                wrap_d = 1'b1;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Paddle segment select
    // ------------------------------------------------------------------
    // If SIDE names no existing player, side_ok stays low and HIT is dropped.
    logic [SEG_W-1:0] seg_code;
    logic             side_ok;

    always_comb begin
        seg_code = '0;
        side_ok  = 1'b0;
        for (int p = 0; p < NPLAYERS; p++) begin
            if (SIDE == SIDE_W'(p)) begin
                seg_code = SEG[p*SEG_W +: SEG_W];
                side_ok  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Speed / direction next state, highest priority first:
    // ATTRACT, then HIT, then wall bounce, else hold.
    // ------------------------------------------------------------------
`ifdef BALL_AXIS_WALL_BOUNCE_EN
    logic bounce;
    assign bounce = FRAME_STB & ball_vid;
`endif

    always_comb begin
        mag_d = mag_q;
        dir_d = dir_q;
        if (ATTRACT) begin
            mag_d = '0;
            dir_d = 1'b0;
        end else if (HIT) begin
            // HIT takes priority even when SIDE is invalid. A bounce in
            // the same cycle is never applied.
            if (side_ok) begin
                mag_d = seg_code[MAG_W-1:0];
                dir_d = seg_code[MAG_W];
            end
        end
`ifdef BALL_AXIS_WALL_BOUNCE_EN
        else if (bounce) begin
            dir_d = ~dir_q;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_DRV or negedge RST_N) begin
        if (!RST_N) begin
            pos_q  <= BASE_POS;
            wrap_q <= 1'b0;
            mag_q  <= '0;
            dir_q  <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            wrap_q <= wrap_d;
            mag_q  <= mag_d;
            dir_q  <= dir_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign POS        = pos_q;
    assign WRAP       = wrap_q;
    assign MAG        = mag_q;
    assign DIR        = dir_q;
    assign BALL_VID   = ball_vid;
    assign BALL_VID_N = ~ball_vid;

endmodule

// File: tb/tb_ball_axis_counter.sv
// Directed bench for ball_axis_counter with the default parameters
// (CNT_W=9, MAG_W=2, NPLAYERS=2, BALL_H=4, BASE_LOAD=4).
// Inputs change on the falling edge. Outputs are sampled on the falling edge.

module tb_ball_axis_counter;

    logic       CLK_DRV;
    logic       RST_N;
    logic       LINE_STB;
    logic       CNT_EN;
    logic       FRAME_STB;
    logic       HIT;
    logic [0:0] SIDE;
    logic [5:0] SEG;
    logic       ATTRACT;
    logic [8:0] POS;
    logic       BALL_VID;
    logic       BALL_VID_N;
    logic       WRAP;
    logic       DIR;
    logic [1:0] MAG;

    int passed;
    int total;

    ball_axis_counter dut (
        .CLK_DRV    (CLK_DRV),
        .RST_N      (RST_N),
        .LINE_STB   (LINE_STB),
        .CNT_EN     (CNT_EN),
        .FRAME_STB  (FRAME_STB),
        .HIT        (HIT),
        .SIDE       (SIDE),
        .SEG        (SEG),
        .ATTRACT    (ATTRACT),
        .POS        (POS),
        .BALL_VID   (BALL_VID),
        .BALL_VID_N (BALL_VID_N),
        .WRAP       (WRAP),
        .DIR        (DIR),
        .MAG        (MAG)
    );

    // Clock
    initial CLK_DRV = 1'b0;
    always #5 CLK_DRV = ~CLK_DRV;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Hold LINE_STB and CNT_EN high for n rising edges. Return on a falling edge.
    task automatic strobes(input int n);
        LINE_STB = 1'b1;
        CNT_EN   = 1'b1;
        repeat (n) @(negedge CLK_DRV);
        LINE_STB = 1'b0;
    endtask

    task automatic pulse_hit(input logic side, input logic [5:0] seg);
        SIDE = side;
        SEG  = seg;
        HIT  = 1'b1;
        @(negedge CLK_DRV);
        HIT  = 1'b0;
    endtask

    int reload_after_bounce;

    initial begin
        passed    = 0;
        total     = 0;
        RST_N     = 1'b0;
        LINE_STB  = 1'b0;
        CNT_EN    = 1'b0;
        FRAME_STB = 1'b0;
        HIT       = 1'b0;
        SIDE      = 1'b0;
        SEG       = 6'd0;
        ATTRACT   = 1'b0;
        repeat (3) @(negedge CLK_DRV);
        RST_N = 1'b1;
        @(negedge CLK_DRV);

        // Reset state
        check("rst_pos", POS, 4);
        check("rst_mag", MAG, 0);
        check("rst_dir", DIR, 0);
        check("rst_vid", BALL_VID, 0);
        check("rst_vid_n", BALL_VID_N, 1);
        check("rst_wrap", WRAP, 0);

        // Count to 300, then assert the asynchronous reset between clock edges.
        strobes(296);
        check("pos_300", POS, 300);
        #2 RST_N = 1'b0;
        #1;
        check("async_rst_pos", POS, 4);
        check("async_rst_vid", BALL_VID, 0);
        check("async_rst_wrap", WRAP, 0);
        @(negedge CLK_DRV);
        RST_N = 1'b1;
        @(negedge CLK_DRV);

        // Walk up to terminal count.
        strobes(503);
        check("pos_507", POS, 507);
        check("vid_507", BALL_VID, 0);
        strobes(1);
        check("pos_508", POS, 508);
        check("vid_508", BALL_VID, 1);
        check("vid_n_508", BALL_VID_N, 0);
        strobes(3);
        check("pos_511", POS, 511);
        check("vid_511", BALL_VID, 1);
        check("wrap_511", WRAP, 0);

        // Strobes without CNT_EN hold the count and never wrap.
        LINE_STB = 1'b1;
        CNT_EN   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK_DRV);
            check("gated_pos", POS, 511);
            check("gated_wrap", WRAP, 0);
        end

        // Wrap to BASE_LOAD with zero speed.
        strobes(1);
        check("wrap0_pos", POS, 4);
        check("wrap0_pulse", WRAP, 1);
        @(negedge CLK_DRV);
        check("wrap0_pulse_end", WRAP, 0);
        check("hold_pos", POS, 4);

        // HIT from player 1 (SEG[1]=3'b011): MAG 3, DIR 0, reload 4+3.
        pulse_hit(1'b1, {3'b011, 3'b100});
        check("hit1_mag", MAG, 3);
        check("hit1_dir", DIR, 0);
        strobes(508);
        check("hit1_reload", POS, 7);
        check("hit1_wrap", WRAP, 1);

        // SEG[1]=3'b111: MAG 3, DIR 1, reload 4-3.
        pulse_hit(1'b1, {3'b111, 3'b100});
        check("hit2_mag", MAG, 3);
        check("hit2_dir", DIR, 1);
        strobes(505);
        check("hit2_reload", POS, 1);

        // Wall bounce with MAG 2, DIR 0.
        pulse_hit(1'b1, {3'b010, 3'b000});
        check("pre_bounce_mag", MAG, 2);
        check("pre_bounce_dir", DIR, 0);
        strobes(507);
        check("bounce_pos", POS, 508);
        check("bounce_vid", BALL_VID, 1);
        FRAME_STB = 1'b1;
        @(negedge CLK_DRV);
        FRAME_STB = 1'b0;
        check("bounce_mag", MAG, 2);
`ifdef BALL_AXIS_WALL_BOUNCE_EN
        check("bounce_dir", DIR, 1);
        reload_after_bounce = 2;
`else
        check("bounce_dir", DIR, 0);
        reload_after_bounce = 6;
`endif
        strobes(4);
        check("bounce_reload", POS, 32'(reload_after_bounce));

        // ATTRACT forces zero speed and ignores HIT.
        ATTRACT = 1'b1;
        @(negedge CLK_DRV);
        pulse_hit(1'b1, {3'b011, 3'b000});
        pulse_hit(1'b0, {3'b000, 3'b111});
        check("attract_mag", MAG, 0);
        check("attract_dir", DIR, 0);
        strobes(512 - reload_after_bounce);
        check("attract_reload", POS, 4);
        ATTRACT = 1'b0;

        // HIT and FRAME_STB in the same cycle with the ball window active:
        // the SEG value wins and DIR does not toggle.
        strobes(504);
        check("tie_vid", BALL_VID, 1);
        FRAME_STB = 1'b1;
        pulse_hit(1'b1, {3'b001, 3'b110});
        FRAME_STB = 1'b0;
        check("tie_mag", MAG, 1);
        check("tie_dir", DIR, 0);

        // Player 0 select (SEG[0]=3'b110): MAG 2, DIR 1, reload 4-2.
        pulse_hit(1'b0, {3'b001, 3'b110});
        check("side0_mag", MAG, 2);
        check("side0_dir", DIR, 1);
        strobes(4);
        check("side0_reload", POS, 2);
        check("side0_wrap", WRAP, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
